bloon_path_walker: RTL

- Moves one bloon along the track encoded in the 20x15 tile map, where each tile is 32x32 px. The pixel position is advanced once per frame strobe.
- It is the requester side of the map lookup interface. It drives a pixel address and samples the returned 1-bit path flag.
- At each tile centre it probes neighbouring tiles to choose its heading. Its output position feeds the bloon sprite and hit-detection logic.

---
 rtl/bloons_pkg.sv | 41 ++++
 rtl/bloon_neighbor_addr.sv | 59 +++++
 rtl/bloon_path_walker.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bloons_pkg.sv
// ============================================================================
//  Module      : bloons_pkg
//  Description : Shared types and tile-grid geometry for the bloon walker.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bloons_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PROBE_FWD   = 3'd1,
        ST_PROBE_LEFT  = 3'd2,
        ST_PROBE_RIGHT = 3'd3,
        ST_MOVE        = 3'd4
    } walker_state_t;

    localparam int TILE_SHIFT  = 5;
    localparam int TILE_CENTRE = 16;
    localparam int GRID_W      = 20;
    localparam int GRID_H      = 15;

    function automatic dir_t turn_left(input dir_t d);
        return dir_t'(d + 2'd3);
    endfunction

    function automatic dir_t turn_right(input dir_t d);
        return dir_t'(d + 2'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bloon_neighbor_addr.sv
// ============================================================================
//  Module      : bloon_neighbor_addr
//  Description : Centre pixel of the adjacent tile in a direction, plus a
//                flag saying whether that tile lies inside the grid.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bloon_neighbor_addr
    import bloons_pkg::*;
(
    input  logic [9:0] i_pos_x,
    input  logic [9:0] i_pos_y,
    input  logic [1:0] i_dir,
    output logic [9:0] o_nb_x,
    output logic [9:0] o_nb_y,
    output logic       o_in_grid
);

    localparam logic [9:0] c_tile_px = 10'(1 << TILE_SHIFT);
    localparam logic [4:0] c_last_tx = 5'(GRID_W - 1);
    localparam logic [4:0] c_last_ty = 5'(GRID_H - 1);

    logic [4:0] w_tx;
    logic [4:0] w_ty;

    assign w_tx = i_pos_x[9:TILE_SHIFT];
    assign w_ty = i_pos_y[9:TILE_SHIFT];

    // Grid edges are judged on tile indices so pixel wrap-around never matters.
    always_comb begin
        o_nb_x    = i_pos_x;
        o_nb_y    = i_pos_y;
        o_in_grid = 1'b0;
        case (dir_t'(i_dir))
            DIR_N: begin
                o_nb_y    = i_pos_y - c_tile_px;
                o_in_grid = (w_ty != 5'd0);
            end
            DIR_E: begin
                o_nb_x    = i_pos_x + c_tile_px;
                o_in_grid = (w_tx < c_last_tx);
            end
            DIR_S: begin
                o_nb_y    = i_pos_y + c_tile_px;
                o_in_grid = (w_ty < c_last_ty);
            end
            DIR_W: begin
                o_nb_x    = i_pos_x - c_tile_px;
                o_in_grid = (w_tx != 5'd0);
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bloon_path_walker.sv
// ============================================================================
//  Module      : bloon_path_walker
//  Description : Walks one bloon along the path tiles of the map, probing
//                forward/left/right at every tile centre.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bloon_path_walker
    import bloons_pkg::*;
#(
    parameter int START_TX  = 0,
    parameter int START_TY  = 7,
    parameter int START_DIR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_step,
    input  logic       start,
    input  logic [1:0] speed_sel,
    output logic [9:0] map_x,
    output logic [9:0] map_y,
    input  logic       map_data,
    output logic [9:0] bloon_x,
    output logic [9:0] bloon_y,
    output logic [1:0] dir,
    output logic       active,
    output logic       escaped,
    output logic       dead_end
);

    localparam logic [9:0] c_start_x   = 10'((START_TX << TILE_SHIFT) + TILE_CENTRE);
    localparam logic [9:0] c_start_y   = 10'((START_TY << TILE_SHIFT) + TILE_CENTRE);
    localparam logic [1:0] c_start_dir = 2'(START_DIR);
    localparam logic [4:0] c_centre    = 5'(TILE_CENTRE);

    walker_state_t r_state;
    dir_t          r_dir;
    logic [9:0]    r_bloon_x, r_bloon_y;
    logic [9:0]    r_map_x, r_map_y;
    logic          r_active, r_escaped, r_dead_end, r_step_pending;

    dir_t       w_probe_dir;
    logic [9:0] w_nb_x, w_nb_y;
    logic       w_in_grid, w_probing, w_path, w_do_step, w_at_centre;
    logic [9:0] w_step, w_next_x, w_next_y;

    always_comb begin
        w_probe_dir = r_dir;
        case (r_state)
            ST_PROBE_LEFT:  w_probe_dir = turn_left(r_dir);
            ST_PROBE_RIGHT: w_probe_dir = turn_right(r_dir);
            default: ;
        endcase
    end

    bloon_neighbor_addr u_nb (
        .i_pos_x   (r_bloon_x),
        .i_pos_y   (r_bloon_y),
        .i_dir     (w_probe_dir),
        .o_nb_x    (w_nb_x),
        .o_nb_y    (w_nb_y),
        .o_in_grid (w_in_grid)
    );

    assign w_probing = (r_state == ST_PROBE_FWD) || (r_state == ST_PROBE_LEFT) ||
                       (r_state == ST_PROBE_RIGHT);
    assign w_path    = w_in_grid & map_data;

    // Off-grid probes issue no query, so the address bus keeps its last value.
    assign map_x = (w_probing && w_in_grid) ? w_nb_x : r_map_x;
    assign map_y = (w_probing && w_in_grid) ? w_nb_y : r_map_y;

    assign w_step    = 10'd1 << speed_sel;
    assign w_do_step = frame_step | r_step_pending;

    always_comb begin
        w_next_x = r_bloon_x;
        w_next_y = r_bloon_y;
        case (r_dir)
            DIR_N:   w_next_y = r_bloon_y - w_step;
            DIR_E:   w_next_x = r_bloon_x + w_step;
            DIR_S:   w_next_y = r_bloon_y + w_step;
            DIR_W:   w_next_x = r_bloon_x - w_step;
            default: ;
        endcase
    end

    assign w_at_centre = (w_next_x[4:0] == c_centre) && (w_next_y[4:0] == c_centre);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_dir          <= dir_t'(c_start_dir);
            r_bloon_x      <= '0;
            r_bloon_y      <= '0;
            r_map_x        <= '0;
            r_map_y        <= '0;
            r_active       <= 1'b0;
            r_escaped      <= 1'b0;
            r_dead_end     <= 1'b0;
            r_step_pending <= 1'b0;
        end else begin
            r_escaped  <= 1'b0;
            r_dead_end <= 1'b0;
            if (w_probing && w_in_grid) begin
                r_map_x <= w_nb_x;
                r_map_y <= w_nb_y;
            end
            if (w_probing && frame_step) begin
                r_step_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bloon_x      <= c_start_x;
                        r_bloon_y      <= c_start_y;
                        r_dir          <= dir_t'(c_start_dir);
                        r_active       <= 1'b1;
                        r_step_pending <= 1'b0;
                        r_state        <= ST_PROBE_FWD;
                    end
                end
                ST_PROBE_FWD: begin
                    if (!w_in_grid) begin
                        r_escaped      <= 1'b1;
                        r_active       <= 1'b0;
                        r_step_pending <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else if (map_data) begin
                        r_state <= ST_MOVE;
                    end else begin
                        r_state <= ST_PROBE_LEFT;
                    end
                end
                ST_PROBE_LEFT: begin
                    if (w_path) begin
                        r_dir   <= w_probe_dir;
                        r_state <= ST_MOVE;
                    end else begin
                        r_state <= ST_PROBE_RIGHT;
                    end
                end
                ST_PROBE_RIGHT: begin
                    if (w_path) begin
                        r_dir   <= w_probe_dir;
                        r_state <= ST_MOVE;
                    end else begin
                        r_dead_end     <= 1'b1;
                        r_active       <= 1'b0;
                        r_step_pending <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                ST_MOVE: begin
                    if (w_do_step) begin
                        r_bloon_x      <= w_next_x;
                        r_bloon_y      <= w_next_y;
                        r_step_pending <= 1'b0;
                        if (w_at_centre) begin
                            r_state <= ST_PROBE_FWD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bloon_x  = r_bloon_x;
    assign bloon_y  = r_bloon_y;
    assign dir      = r_dir;
    assign active   = r_active;
    assign escaped  = r_escaped;
    assign dead_end = r_dead_end;

endmodule

`default_nettype wire
